// File: rtl/wb_write_queue_pkg.sv
// Shared constants for the writeback queue: register x0 value and entry source tags.
// Entry layout is {src, rd, data}; the src bit only drives decisions when WB_BYPASS_EN is defined.
package wb_write_queue_pkg;

    localparam int unsigned REG_X0 = 0;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_write_queue_fifo.sv
// Dual-push, single-pop circular buffer; entries are also presented in age order
// (index 0 = head) so the parent can compare every pending destination register.
module wb_fifo
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ENT_W = 38,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_a,
    input  logic [ENT_W-1:0]            din_a,
    input  logic                        push_b,
    input  logic [ENT_W-1:0]            din_b,
    input  logic                        pop,
    output logic [ENT_W-1:0]            head,
    output logic [CNT_W-1:0]            count,
    output logic [DEPTH-1:0]            age_valid,
    output logic [DEPTH-1:0][ENT_W-1:0] age_ent
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_nx;
    logic [CNT_W-1:0] count_q, count_d;

    // push_b is only ever asserted together with push_a, so it lands one slot later.
    always_comb begin
        wr_ptr_nx = wr_ptr_q + PTR_W'(1);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_a) mem_q[wr_ptr_q]  <= din_a;
        if (push_b) mem_q[wr_ptr_nx] <= din_b;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PTR_W-1:0] idx;
        assign idx           = rd_ptr_q + PTR_W'(gi);
        assign age_ent[gi]   = mem_q[idx];
        assign age_valid[gi] = (CNT_W'(gi) < count_q);
    end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue feeding the integer register file write port, with decoder hazard flags.
// Define WB_BYPASS_EN to add forwarding outputs; hazards then only stall on pending loads.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    input  logic              wb_stall,
    input  logic [ADDR_W-1:0] rs_p0,
    input  logic [ADDR_W-1:0] rs_p1,
    output logic              hz_p0,
    output logic              hz_p1,
    output logic              we_p2,
    output logic [ADDR_W-1:0] addr_p2,
    output logic [DATA_W-1:0] din_p2,
    output logic              empty
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_hit_p0,
    output logic              byp_hit_p1,
    output logic [DATA_W-1:0] byp_data_p0,
    output logic [DATA_W-1:0] byp_data_p1
`endif
);

    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int RD_LO = DATA_W;
    localparam int RD_HI = DATA_W + ADDR_W - 1;

    logic [CNT_W-1:0]            count;
    logic [ENT_W-1:0]            head;
    logic [DEPTH-1:0]            age_valid;
    logic [DEPTH-1:0][ENT_W-1:0] age_ent;
    logic                        lsu_push, alu_push, push_a, push_b, pop;
    logic [ENT_W-1:0]            lsu_ent, alu_ent, din_a;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
`ifdef WB_BYPASS_EN
    logic              src_q, src_d;
`endif

    // Readiness depends only on the registered count; a pop this cycle does not free a slot early.
    assign lsu_ready = (count <= CNT_W'(DEPTH - 1));
    assign alu_ready = lsu_valid ? (count <= CNT_W'(DEPTH - 2)) : (count <= CNT_W'(DEPTH - 1));

    assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != ADDR_W'(REG_X0));
    assign alu_push = alu_valid && alu_ready && (alu_rd != ADDR_W'(REG_X0));
    assign lsu_ent  = {SRC_LSU, lsu_rd, lsu_data};
    assign alu_ent  = {SRC_ALU, alu_rd, alu_data};
    assign push_a   = lsu_push || alu_push;
    assign din_a    = lsu_push ? lsu_ent : alu_ent;
    assign push_b   = lsu_push && alu_push;
    assign pop      = (count != '0) && !wb_stall;

    wb_fifo #(
        .DEPTH (DEPTH),
        .ENT_W (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_a    (push_a),
        .din_a     (din_a),
        .push_b    (push_b),
        .din_b     (alu_ent),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .age_valid (age_valid),
        .age_ent   (age_ent)
    );

    // The register file masks reads matching addr_p2, so the address must return to x0 when idle.
    always_comb begin
        we_d   = 1'b0;
        addr_d = '0;
        din_d  = din_q;
`ifdef WB_BYPASS_EN
        src_d  = src_q;
`endif
        if (pop) begin
            we_d   = 1'b1;
            addr_d = head[RD_HI:RD_LO];
            din_d  = head[DATA_W-1:0];
`ifdef WB_BYPASS_EN
            src_d  = head[ENT_W-1];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
`ifdef WB_BYPASS_EN
            src_q  <= SRC_ALU;
`endif
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            din_q  <= din_d;
`ifdef WB_BYPASS_EN
            src_q  <= src_d;
`endif
        end
    end

    assign we_p2   = we_q;
    assign addr_p2 = addr_q;
    assign din_p2  = din_q;
    assign empty   = (count == '0) && !we_q;

    logic [ADDR_W-1:0] rs_sel [2];
    logic [1:0]        hz_vec;
    assign rs_sel[0] = rs_p0;
    assign rs_sel[1] = rs_p1;

`ifdef WB_BYPASS_EN
    logic [1:0]        hit_vec;
    logic [DATA_W-1:0] bdata_vec [2];
`endif

    // Scan oldest to youngest (output register, then FIFO head..tail) so the last match wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic hz;
`ifdef WB_BYPASS_EN
        logic              hit;
        logic [DATA_W-1:0] bdat;
`endif
        always_comb begin
            hz = 1'b0;
`ifdef WB_BYPASS_EN
            hit  = 1'b0;
            bdat = '0;
`endif
            if (rs_sel[gi] != ADDR_W'(REG_X0)) begin
                if (we_q && (addr_q == rs_sel[gi])) begin
`ifdef WB_BYPASS_EN
                    hit  = 1'b1;
                    bdat = din_q;
                    hz   = hz || (src_q == SRC_LSU);
`else
                    hz   = 1'b1;
`endif
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (age_valid[k] && (age_ent[k][RD_HI:RD_LO] == rs_sel[gi])) begin
`ifdef WB_BYPASS_EN
                        hit  = 1'b1;
                        bdat = age_ent[k][DATA_W-1:0];
                        hz   = hz || (age_ent[k][ENT_W-1] == SRC_LSU);
`else
                        hz   = 1'b1;
`endif
                    end
                end
            end
        end
        assign hz_vec[gi] = hz;
`ifdef WB_BYPASS_EN
        assign hit_vec[gi]   = hit;
        assign bdata_vec[gi] = bdat;
`endif
    end

    assign hz_p0 = hz_vec[0];
    assign hz_p1 = hz_vec[1];

`ifdef WB_BYPASS_EN
    assign byp_hit_p0  = hit_vec[0];
    assign byp_hit_p1  = hit_vec[1];
    assign byp_data_p0 = bdata_vec[0];
    assign byp_data_p1 = bdata_vec[1];
`else
    // Source tag and entry data only matter for forwarding.
    logic unused_fields;
    assign unused_fields = ^{age_ent, head[ENT_W-1]};
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue with a scoreboard of expected register file writes.
// Builds with or without WB_BYPASS_EN; forwarding checks are added when it is defined.
module tb_wb_write_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              alu_valid = 1'b0, lsu_valid = 1'b0, wb_stall = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0, lsu_rd = '0, rs_p0 = '0, rs_p1 = '0;
    logic [DATA_W-1:0] alu_data = '0, lsu_data = '0;
    logic              alu_ready, lsu_ready, hz_p0, hz_p1, we_p2, empty;
    logic [ADDR_W-1:0] addr_p2;
    logic [DATA_W-1:0] din_p2;
`ifdef WB_BYPASS_EN
    logic              byp_hit_p0, byp_hit_p1;
    logic [DATA_W-1:0] byp_data_p0, byp_data_p1;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;

    wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .wb_stall  (wb_stall),
        .rs_p0     (rs_p0),
        .rs_p1     (rs_p1),
        .hz_p0     (hz_p0),
        .hz_p1     (hz_p1),
        .we_p2     (we_p2),
        .addr_p2   (addr_p2),
        .din_p2    (din_p2),
        .empty     (empty)
`ifdef WB_BYPASS_EN
        ,
        .byp_hit_p0  (byp_hit_p0),
        .byp_hit_p1  (byp_hit_p1),
        .byp_data_p0 (byp_data_p0),
        .byp_data_p1 (byp_data_p1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write-port pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (reset === 1'b0 && we_p2 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'(we_p2), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_addr", 64'(addr_p2), 64'(e.rd));
                check("wb_data", 64'(din_p2), 64'(e.data));
            end
        end
    end

    // Offer one ALU result that must be accepted immediately; returns at the next falling edge.
    task automatic alu_put(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        #1;
        check("alu_ready_put", 64'(alu_ready), 64'd1);
        if (rd != '0) exp_q.push_back('{rd: rd, data: d});
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rs_p0 = 5'd7;
        rs_p1 = 5'd3;
        @(negedge clk);
        check("rst_we",     64'(we_p2),     64'd0);
        check("rst_addr",   64'(addr_p2),   64'd0);
        check("rst_din",    64'(din_p2),    64'd0);
        check("rst_empty",  64'(empty),     64'd1);
        check("rst_hz0",    64'(hz_p0),     64'd0);
        check("rst_hz1",    64'(hz_p1),     64'd0);
        check("rst_alu_rdy",64'(alu_ready), 64'd1);
        check("rst_lsu_rdy",64'(lsu_ready), 64'd1);
        rs_p0 = '0;
        rs_p1 = '0;

        // Single ALU write: latency of two edges.
        @(negedge clk);
        reset = 1'b0;
        alu_put(5'd5, 32'hDEADBEEF);
        check("lat_we_k",     64'(we_p2), 64'd0);
        check("lat_empty_k",  64'(empty), 64'd0);
        @(negedge clk);
        check("lat_we_k1",    64'(we_p2), 64'd1);
        check("lat_addr_k1",  64'(addr_p2), 64'd5);
        @(negedge clk);
        check("lat_we_k2",    64'(we_p2), 64'd0);
        check("lat_addr_idle",64'(addr_p2), 64'd0);
        check("lat_din_hold", 64'(din_p2), 64'hDEADBEEF);
        check("lat_empty_k2", 64'(empty), 64'd1);

        // Simultaneous LSU and ALU: LSU drains first.
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        #1;
        check("dual_lsu_rdy", 64'(lsu_ready), 64'd1);
        check("dual_alu_rdy", 64'(alu_ready), 64'd1);
        exp_q.push_back('{rd: 5'd3, data: 32'h11});
        exp_q.push_back('{rd: 5'd4, data: 32'h22});
        @(negedge clk);
        lsu_valid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        check("dual_first",  64'(addr_p2), 64'd3);
        @(negedge clk);
        check("dual_second", 64'(addr_p2), 64'd4);
        @(negedge clk);
        check("dual_empty",  64'(empty), 64'd1);

        // Fill under stall, probe ready boundaries, then drain.
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                lsu_valid = 1'b1; lsu_rd = 5'd1;
                #1;
                check("bnd_alu_rdy_lsuv", 64'(alu_ready), 64'd0);
                check("bnd_lsu_rdy_3",    64'(lsu_ready), 64'd1);
                lsu_valid = 1'b0;
                #1;
            end
            alu_put(ADDR_W'(10 + i), DATA_W'(32'h100 + i));
        end
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h104;
        #1;
        check("full_alu_rdy", 64'(alu_ready), 64'd0);
        check("full_lsu_rdy", 64'(lsu_ready), 64'd0);
        check("full_we",      64'(we_p2),     64'd0);
        @(negedge clk);
        check("full_alu_rdy2",64'(alu_ready), 64'd0);
        wb_stall = 1'b0;
        #1;
        t = 0;
        while (!alu_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain_ready",  64'(alu_ready), 64'd1);
        check("drain_wait",   64'(t), 64'd1);
        exp_q.push_back('{rd: 5'd14, data: 32'h104});
        @(negedge clk);
        alu_valid = 1'b0;
        t = 0;
        while (!empty && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty",  64'(empty), 64'd1);
        check("drain_sb",     64'(exp_q.size()), 64'd0);

        // x0 destination: handshaken, never written.
        alu_put(5'd0, 32'h55);
        for (int i = 0; i < 3; i++) begin
            check("x0_we",    64'(we_p2),   64'd0);
            check("x0_addr",  64'(addr_p2), 64'd0);
            check("x0_empty", 64'(empty),   64'd1);
            @(negedge clk);
        end

        // Hazard tracking through the FIFO and the output register.
        wb_stall = 1'b1;
        alu_put(5'd7, 32'h77);
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
        #1;
        check("hz_lsu_rdy", 64'(lsu_ready), 64'd1);
        exp_q.push_back('{rd: 5'd8, data: 32'h88});
        @(negedge clk);
        lsu_valid = 1'b0;
        rs_p0 = 5'd7; rs_p1 = 5'd0;
        #1;
        check("hz_x0_p1", 64'(hz_p1), 64'd0);
`ifdef WB_BYPASS_EN
        check("hz_p0_alu_byp", 64'(hz_p0),      64'd0);
        check("byp_hit_p0",    64'(byp_hit_p0), 64'd1);
        check("byp_data_p0",   64'(byp_data_p0),64'h77);
`else
        check("hz_p0_fifo",    64'(hz_p0),      64'd1);
`endif
        rs_p1 = 5'd8;
        #1;
        check("hz_p1_lsu", 64'(hz_p1), 64'd1);
`ifdef WB_BYPASS_EN
        check("byp_data_p1", 64'(byp_data_p1), 64'h88);
`endif
        wb_stall = 1'b0;
        @(negedge clk);
        check("hz_out7_we", 64'(we_p2), 64'd1);
`ifdef WB_BYPASS_EN
        check("hz_out7_hit", 64'(byp_hit_p0), 64'd1);
        check("hz_out7_hz",  64'(hz_p0),      64'd0);
`else
        check("hz_out7_hz",  64'(hz_p0),      64'd1);
`endif
        check("hz_p1_q",     64'(hz_p1), 64'd1);
        @(negedge clk);
        check("hz_p0_clear", 64'(hz_p0), 64'd0);
        check("hz_out8_hz",  64'(hz_p1), 64'd1);
        @(negedge clk);
        check("hz_p1_clear", 64'(hz_p1), 64'd0);
        check("hz_idle_we",  64'(we_p2), 64'd0);
        rs_p0 = '0; rs_p1 = '0;

        // Asynchronous reset with entries queued and a write in flight.
        wb_stall = 1'b1;
        alu_put(5'd20, 32'h200);
        alu_put(5'd21, 32'h201);
        alu_put(5'd22, 32'h202);
        wb_stall = 1'b0;
        @(negedge clk);
        check("ar_we_before", 64'(we_p2), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_we",    64'(we_p2),   64'd0);
        check("ar_addr",  64'(addr_p2), 64'd0);
        check("ar_din",   64'(din_p2),  64'd0);
        check("ar_empty", 64'(empty),   64'd1);
        check("ar_lsu_rdy", 64'(lsu_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ar_no_write", 64'(we_p2), 64'd0);
        end
        check("final_sb", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
